stream_response_checker: RTL and testbench

- Synthesizable response checker: the receiving end of the team's vector-driven test flow.
- Drives no stimulus. It accepts a stream of observed DUT output words over a valid/ready handshake and compares each word against an internally regenerated expected sequence, a Galois LFSR matching the paired stimulus generator.
- Reports match/mismatch counts, first-failure details and a final pass flag.
- Used in on-chip self-test wrappers and in simulation benches as a scoreboard.

---
 rtl/stream_response_checker_if.sv | 12 +
 rtl/stream_response_checker.sv | 123 ++++++++++++
 tb/tb_stream_response_checker.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_response_checker_if.sv
// Observed-word stream between a DUT (or its wrapper) and the response checker.
// The master drives words; the slave (checker) signals readiness.
interface stream_response_checker_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              obs_valid;
    logic [DATA_W-1:0] obs_data;
    logic              obs_ready;

    modport master (output obs_valid, output obs_data, input obs_ready);
    modport slave  (input obs_valid, input obs_data, output obs_ready);
endinterface

// File: rtl/stream_response_checker.sv
// Response checker: compares a stream of observed words against a regenerated Galois LFSR
// sequence and reports match/mismatch counts, first-failure details and a pass flag.
module stream_response_checker #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       NUM_VECTORS = 16,
    parameter logic [DATA_W-1:0] SEED        = DATA_W'(8'h01),
    parameter logic [DATA_W-1:0] TAPS        = DATA_W'(8'hB8),
    parameter int unsigned       CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    stream_response_checker_if.slave  obs,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      err_seen,
    output logic [CNT_W-1:0]          match_cnt,
    output logic [CNT_W-1:0]          mismatch_cnt,
    output logic [CNT_W-1:0]          first_err_idx,
    output logic [DATA_W-1:0]         first_err_exp,
    output logic [DATA_W-1:0]         first_err_obs
);

    // idx is sized from NUM_VECTORS, not CNT_W, so tiny counters cannot stall the run
    localparam int unsigned       IdxW    = $clog2(NUM_VECTORS + 1);
    localparam logic [IdxW-1:0]   LastIdx = IdxW'(NUM_VECTORS - 1);
    localparam logic [DATA_W-1:0] SeedEff = (SEED == '0) ? DATA_W'(1) : SEED;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] lfsr_q, lfsr_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]  match_q, match_d;
    logic [CNT_W-1:0]  mismatch_q, mismatch_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  fe_idx_q, fe_idx_d;
    logic [DATA_W-1:0] fe_exp_q, fe_exp_d;
    logic [DATA_W-1:0] fe_obs_q, fe_obs_d;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        idx_d      = idx_q;
        match_d    = match_q;
        mismatch_d = mismatch_q;
        err_d      = err_q;
        fe_idx_d   = fe_idx_q;
        fe_exp_d   = fe_exp_q;
        fe_obs_d   = fe_obs_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StRun;
                    lfsr_d     = SeedEff;
                    idx_d      = '0;
                    match_d    = '0;
                    mismatch_d = '0;
                    err_d      = 1'b0;
                    fe_idx_d   = '0;
                    fe_exp_d   = '0;
                    fe_obs_d   = '0;
                end
            end
            StRun: begin
                if (obs.obs_valid) begin
                    if (obs.obs_data == lfsr_q) begin
                        if (match_q != '1) match_d = match_q + 1'b1;
                    end else begin
                        if (mismatch_q != '1) mismatch_d = mismatch_q + 1'b1;
                        if (!err_q) begin
                            err_d    = 1'b1;
                            fe_idx_d = CNT_W'(idx_q);
                            fe_exp_d = lfsr_q;
                            fe_obs_d = obs.obs_data;
                        end
                    end
                    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == LastIdx) state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lfsr_q     <= SeedEff;
            idx_q      <= '0;
            match_q    <= '0;
            mismatch_q <= '0;
            err_q      <= 1'b0;
            fe_idx_q   <= '0;
            fe_exp_q   <= '0;
            fe_obs_q   <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            idx_q      <= idx_d;
            match_q    <= match_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            fe_idx_q   <= fe_idx_d;
            fe_exp_q   <= fe_exp_d;
            fe_obs_q   <= fe_obs_d;
        end
    end

    assign obs.obs_ready  = (state_q == StRun);
    assign busy           = (state_q == StRun);
    assign done           = (state_q == StDone);
    assign pass           = (state_q == StDone) && (mismatch_q == '0);
    assign err_seen       = err_q;
    assign match_cnt      = match_q;
    assign mismatch_cnt   = mismatch_q;
    assign first_err_idx  = fe_idx_q;
    assign first_err_exp  = fe_exp_q;
    assign first_err_obs  = fe_obs_q;

endmodule

// File: tb/tb_stream_response_checker.sv
// Directed, table-driven bench for stream_response_checker plus two parameter-corner instances.
module tb_stream_response_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    stream_response_checker_if #(.DATA_W(8)) if0 ();
    stream_response_checker_if #(.DATA_W(8)) if1 ();
    stream_response_checker_if #(.DATA_W(8)) if2 ();

    logic        busy0, done0, pass0, err0;
    logic [15:0] mc0, mm0, fei0;
    logic [7:0]  fee0, feo0;
    logic        busy1, done1, pass1, err1;
    logic [15:0] mc1, mm1, fei1;
    logic [7:0]  fee1, feo1;
    logic        busy2, done2, pass2, err2;
    logic [1:0]  mc2, mm2, fei2;
    logic [7:0]  fee2, feo2;

    stream_response_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .obs(if0.slave),
        .busy(busy0), .done(done0), .pass(pass0), .err_seen(err0),
        .match_cnt(mc0), .mismatch_cnt(mm0), .first_err_idx(fei0),
        .first_err_exp(fee0), .first_err_obs(feo0)
    );

    stream_response_checker #(.NUM_VECTORS(1), .SEED(8'h00)) dut_one (
        .clk(clk), .rst_n(rst_n), .start(start1), .obs(if1.slave),
        .busy(busy1), .done(done1), .pass(pass1), .err_seen(err1),
        .match_cnt(mc1), .mismatch_cnt(mm1), .first_err_idx(fei1),
        .first_err_exp(fee1), .first_err_obs(feo1)
    );

    stream_response_checker #(.NUM_VECTORS(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .obs(if2.slave),
        .busy(busy2), .done(done2), .pass(pass2), .err_seen(err2),
        .match_cnt(mc2), .mismatch_cnt(mm2), .first_err_idx(fei2),
        .first_err_exp(fee2), .first_err_obs(feo2)
    );

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        exp_busy;
        logic        exp_done;
        logic [15:0] exp_match;
        logic [15:0] exp_mis;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] seq [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send0(input logic [7:0] w);
        if0.obs_valid = 1'b1;
        if0.obs_data  = w;
        step();
        if0.obs_valid = 1'b0;
    endtask

    initial begin
        vec_t       v;
        logic [7:0] w;
        int         m, mis;

        seq = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8,
                8'h64, 8'h32, 8'h19, 8'hB4, 8'h5A, 8'h2D, 8'hAE, 8'h57};

        // Injected-error run: word 3 sent as 2F, word 7 sent as 37.
        vecs.push_back('{0, 1, 8'h01, 0, 0, 16'd0, 16'd0, 0});   // valid in IDLE ignored
        vecs.push_back('{1, 0, 8'hFF, 1, 0, 16'd0, 16'd0, 0});   // start
        m = 0;
        mis = 0;
        for (int i = 0; i < 16; i++) begin
            w = seq[i];
            if (i == 3) w = 8'h2F;
            if (i == 7) w = 8'h37;
            if (w == seq[i]) m++; else mis++;
            v = '{(i == 5), 1'b1, w, (i != 15), (i == 15), 16'(m), 16'(mis), (mis != 0)};
            vecs.push_back(v);
            if (i == 9) vecs.push_back('{0, 0, 8'h00, 1, 0, 16'(m), 16'(mis), 1});
        end
        vecs.push_back('{0, 1, 8'h01, 0, 1, 16'd14, 16'd2, 1}); // DONE ignores words

        if0.obs_valid = 1'b0; if0.obs_data = '0;
        if1.obs_valid = 1'b0; if1.obs_data = '0;
        if2.obs_valid = 1'b0; if2.obs_data = '0;

        // Reset state
        step();
        step();
        check("rst_ready", if0.obs_ready, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err", err0, 0);
        check("rst_match", mc0, 0);
        check("rst_mismatch", mm0, 0);
        check("rst_fei", fei0, 0);
        rst_n = 1'b1;
        step();

        // Table run
        for (int k = 0; k < vecs.size(); k++) begin
            start0        = vecs[k].start;
            if0.obs_valid = vecs[k].valid;
            if0.obs_data  = vecs[k].data;
            step();
            check($sformatf("vec%0d_busy", k), busy0, vecs[k].exp_busy);
            check($sformatf("vec%0d_done", k), done0, vecs[k].exp_done);
            check($sformatf("vec%0d_match", k), mc0, vecs[k].exp_match);
            check($sformatf("vec%0d_mismatch", k), mm0, vecs[k].exp_mis);
            check($sformatf("vec%0d_err", k), err0, vecs[k].exp_err);
        end
        start0 = 1'b0;
        if0.obs_valid = 1'b0;
        check("err_pass", pass0, 0);
        check("err_fei", fei0, 3);
        check("err_fee", fee0, 8'h2E);
        check("err_feo", feo0, 8'h2F);

        // Restart from DONE; clean sequence with gaps and start pulses during RUN
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        check("rs_busy", busy0, 1);
        check("rs_match_clr", mc0, 0);
        check("rs_mis_clr", mm0, 0);
        check("rs_err_clr", err0, 0);
        check("rs_fei_clr", fei0, 0);
        check("rs_feo_clr", feo0, 0);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 2)) begin
                if0.obs_valid = 1'b0;
                if0.obs_data  = 8'($urandom);
                start0 = (i == 4);
                step();
                start0 = 1'b0;
            end
            start0 = (i == 8);
            send0(seq[i]);
            start0 = 1'b0;
            if (i == 14) check("rs_not_done", done0, 0);
        end
        check("rs_done", done0, 1);
        check("rs_pass", pass0, 1);
        check("rs_match", mc0, 16);
        check("rs_mismatch", mm0, 0);
        check("rs_err", err0, 0);
        step();
        check("rs_done_hold", done0, 1);

        // Mid-run asynchronous reset after 5 transfers
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 5; i++) send0(seq[i]);
        check("mr_match_pre", mc0, 5);
        #3 rst_n = 1'b0;
        #1;
        check("mr_busy", busy0, 0);
        check("mr_match", mc0, 0);
        check("mr_ready", if0.obs_ready, 0);
        #2 rst_n = 1'b1;
        step();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        send0(8'h01);
        check("mr_first_match", mc0, 1);
        check("mr_first_mis", mm0, 0);

        // NUM_VECTORS=1, SEED=0: first expected word is 01
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        if1.obs_valid = 1'b1;
        if1.obs_data  = 8'h01;
        step();
        if1.obs_valid = 1'b0;
        check("one_done", done1, 1);
        check("one_pass", pass1, 1);
        check("one_match", mc1, 1);

        // CNT_W=2, NUM_VECTORS=5: match count saturates at 3
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if2.obs_valid = 1'b1;
            if2.obs_data  = seq[i];
            step();
        end
        if2.obs_valid = 1'b0;
        check("sat_done", done2, 1);
        check("sat_match", mc2, 3);
        check("sat_pass", pass2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
